// File: rtl/muldiv_pkg.sv
// Shared uop definitions for the MDU slice.
// Issue bundle, op/class enums and writeback meta.
package muldiv_pkg;

  localparam int ROB_W  = 5;
  localparam int PHYS_W = 6;

  typedef enum logic [1:0] {
    UOP_ALU, UOP_LSU, UOP_BRU, UOP_MDU
  } uop_class_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } uop_op_e;

  typedef struct packed {
    uop_class_e        cls;
    uop_op_e           op;
    logic [31:0]       pc;
    logic              uses_rd;
    logic [ROB_W-1:0]  rob_idx;
    logic [1:0]        epoch;
    logic [PHYS_W-1:0] prd_new;
  } rs_uop_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic              uses_rd;
    logic [ROB_W-1:0]  rob_idx;
    logic [1:0]        epoch;
    logic [PHYS_W-1:0] prd_new;
  } wb_meta_t;

  function automatic wb_meta_t meta_of(
    input rs_uop_t u
  );
    wb_meta_t m;
    m.pc      = u.pc;
    m.uses_rd = u.uses_rd;
    m.rob_idx = u.rob_idx;
    m.epoch   = u.epoch;
    m.prd_new = u.prd_new;
    return m;
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on magnitudes.
// Sign fix-up applied on the way out.
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_FAST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            sgn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            ack,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DONE
  } div_state_e;

  div_state_e st, st_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dvs;
  logic            neg_q, neg_r;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, ovf, special;
  logic [XLEN:0]   tmp;
  logic            ge;
  logic [XLEN-1:0] diff;

  assign a_neg   = sgn & a[XLEN-1];
  assign b_neg   = sgn & b[XLEN-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign b_zero  = (b == '0);
  assign ovf     = sgn && (a == {1'b1, {(XLEN-1){1'b0}}})
                 && (b == '1);
  assign special = (DIV_FAST != 0) && (b_zero || ovf);

  assign tmp  = {rem, quo[XLEN-1]};
  assign ge   = (tmp >= {1'b0, dvs});
  assign diff = tmp[XLEN-1:0] - dvs;

  assign busy      = (st != S_IDLE);
  assign done      = (st == S_DONE);
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  // next-state: special cases skip RUN when fast
  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE: if (start) st_nxt = special ? S_DONE : S_RUN;
      S_RUN:  if (cnt == CW'(XLEN-1)) st_nxt = S_DONE;
      S_DONE: if (ack) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
    if (flush) st_nxt = S_IDLE;
  end

  // operand load and one quotient bit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (st == S_IDLE && start) begin
      cnt   <= '0;
      dvs   <= b_mag;
      neg_q <= (a_neg ^ b_neg) & ~b_zero;
      neg_r <= a_neg;
      if (special) begin
        quo <= b_zero ? '1 : a_mag;
        rem <= b_zero ? a_mag : '0;
      end else begin
        quo <= a_mag;
        rem <= '0;
      end
    end else if (st == S_RUN) begin
      rem <= ge ? diff : tmp[XLEN-1:0];
      quo <= {quo[XLEN-2:0], ge};
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M unit: pipelined multiplier plus iterative
// divider sharing one writeback port.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3,
  parameter int DIV_FAST   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  rs_uop_t           req_uop,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_pc,
  output logic              wb_uses_rd,
  output logic [ROB_W-1:0]  wb_rob_idx,
  output logic [PHYS_W-1:0] wb_prd_new,
  output logic [1:0]        wb_epoch,
  output logic [XLEN-1:0]   wb_data
);

  localparam int T = MUL_STAGES - 1;

  logic is_mul, is_div, mul_hi;
  logic a_sgn, b_sgn, div_sgn, div_rem;

  logic [XLEN:0]     a_ext, b_ext;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0]   mul_res;

  logic            mv [MUL_STAGES];
  wb_meta_t        mm [MUL_STAGES];
  logic [XLEN-1:0] md [MUL_STAGES];

  logic            tail_v, mul_gnt, mul_adv, acc;
  logic            div_busy, div_done, div_ack;
  logic [XLEN-1:0] div_q, div_r;
  wb_meta_t        dmeta, wb_m;
  logic            drem;

  // op decode; anything outside the MDU class is refused
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    mul_hi  = 1'b0;
    a_sgn   = 1'b0;
    b_sgn   = 1'b0;
    div_sgn = 1'b0;
    div_rem = 1'b0;
    if (req_uop.cls == UOP_MDU) begin
      unique case (req_uop.op)
        OP_MUL: is_mul = 1'b1;
        OP_MULH: begin
          is_mul = 1'b1; mul_hi = 1'b1;
          a_sgn  = 1'b1; b_sgn  = 1'b1;
        end
        OP_MULHSU: begin
          is_mul = 1'b1; mul_hi = 1'b1;
          a_sgn  = 1'b1;
        end
        OP_MULHU: begin
          is_mul = 1'b1; mul_hi = 1'b1;
        end
        OP_DIV: begin
          is_div = 1'b1; div_sgn = 1'b1;
        end
        OP_DIVU: is_div = 1'b1;
        OP_REM: begin
          is_div  = 1'b1; div_sgn = 1'b1;
          div_rem = 1'b1;
        end
        OP_REMU: begin
          is_div = 1'b1; div_rem = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign a_ext   = {a_sgn & rs1_val[XLEN-1], rs1_val};
  assign b_ext   = {b_sgn & rs2_val[XLEN-1], rs2_val};
  assign a_w     = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
  assign b_w     = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
  assign prod    = a_w * b_w;
  assign mul_res = mul_hi ? prod[2*XLEN-1:XLEN]
                          : prod[XLEN-1:0];

  assign tail_v   = mv[T];
  assign mul_gnt  = !flush && !div_done && tail_v && wb_ready;
  assign mul_adv  = !tail_v || mul_gnt;
  assign div_ack  = !flush && div_done && wb_ready;
  assign req_ready = !flush
                   && ((is_mul && mul_adv) || (is_div && !div_busy));
  assign acc      = req_valid && req_ready;
  assign wb_valid = !flush && (div_done || tail_v);

  // mul pipe: whole pipe freezes while the tail waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        mv[i] <= 1'b0;
        mm[i] <= '0;
        md[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < MUL_STAGES; i++) mv[i] <= 1'b0;
    end else if (mul_adv) begin
      mv[0] <= acc && is_mul;
      if (acc && is_mul) begin
        mm[0] <= meta_of(req_uop);
        md[0] <= mul_res;
      end
      for (int i = 1; i < MUL_STAGES; i++) begin
        mv[i] <= mv[i-1];
        mm[i] <= mm[i-1];
        md[i] <= md[i-1];
      end
    end
  end

  // divider payload captured at issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmeta <= '0;
      drem  <= 1'b0;
    end else if (acc && is_div) begin
      dmeta <= meta_of(req_uop);
      drem  <= div_rem;
    end
  end

  muldiv_div_iter #(
    .XLEN     (XLEN),
    .DIV_FAST (DIV_FAST)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (acc && is_div),
    .sgn       (div_sgn),
    .a         (rs1_val),
    .b         (rs2_val),
    .ack       (div_ack),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // writeback mux: a finished divide wins over the mul tail
  always_comb begin
    wb_m    = mm[T];
    wb_data = md[T];
    if (div_done) begin
      wb_m    = dmeta;
      wb_data = drem ? div_r : div_q;
    end
  end

  assign wb_pc      = wb_m.pc;
  assign wb_uses_rd = wb_m.uses_rd;
  assign wb_rob_idx = wb_m.rob_idx;
  assign wb_prd_new = wb_m.prd_new;
  assign wb_epoch   = wb_m.epoch;

endmodule
